// File: rtl/move_match_scorer_if.sv
// Bundle of the move-entry controls and the score/result outputs of the
// move/match scorer. The master side drives the buttons and moves, and the
// slave side (the scorer) drives the scores and the match flags.
interface move_match_scorer_if #(
  parameter int NUM_MOVES = 3,
  parameter int DIGITS    = 2
);
  logic                   enter;
  logic                   newGame;
  logic [NUM_MOVES-1:0]   hMove;
  logic [NUM_MOVES-1:0]   cMove;
  logic [4*DIGITS-1:0]    hScore;
  logic [4*DIGITS-1:0]    cScore;
  logic [1:0]             roundResult;
  logic                   badMove;
  logic                   win;
  logic                   lose;

  modport master (
    output enter, newGame, hMove, cMove,
    input  hScore, cScore, roundResult, badMove, win, lose
  );

  modport slave (
    input  enter, newGame, hMove, cMove,
    output hScore, cScore, roundResult, badMove, win, lose
  );
endinterface

// File: rtl/move_match_scorer.sv
// Scorekeeper for the human-vs-computer move game. Each rising edge of the
// enter button compares the one-hot human and computer moves, updates the
// BCD round-win counts and ends the match once a player reaches WIN_SCORE.
// A move beats the move whose index is one below it, cyclically.
module move_match_scorer #(
  parameter int NUM_MOVES = 3,
  parameter int DIGITS    = 2,
  parameter int WIN_SCORE = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  move_match_scorer_if.slave    bus
);

  typedef enum logic {PLAY, DONE} stateT;

  localparam int SW = 4 * DIGITS;

  // Convert an integer to packed BCD, least significant digit in the low nibble.
  function automatic logic [SW-1:0] toBcd(input int value);
    logic [SW-1:0] result;
    int rest;
    result = '0;
    rest   = value;
    for (int k = 0; k < DIGITS; k++) begin
      result[4*k +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return result;
  endfunction

  // Ripple-carry BCD increment; an all-9s value saturates instead of wrapping.
  function automatic logic [SW-1:0] bcdInc(input logic [SW-1:0] score);
    logic [SW-1:0] result;
    logic          carry;
    logic          allNines;
    logic [3:0]    digit;
    allNines = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (score[4*k +: 4] != 4'd9) allNines = 1'b0;
    end
    result = score;
    carry  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      digit = score[4*k +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          digit = 4'd0;
        end else begin
          digit = digit + 4'd1;
          carry = 1'b0;
        end
      end
      result[4*k +: 4] = digit;
    end
    return allNines ? score : result;
  endfunction

  // Position of the highest set bit; only meaningful for one-hot inputs.
  function automatic int moveIndex(input logic [NUM_MOVES-1:0] move);
    int idx;
    idx = 0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      if (move[i]) idx = i;
    end
    return idx;
  endfunction

  localparam logic [SW-1:0] WIN_BCD = toBcd(WIN_SCORE);

  stateT          currState, nextState;
  logic           enterQ;
  logic           press;
  logic [SW-1:0]  hScoreQ, hScoreD;
  logic [SW-1:0]  cScoreQ, cScoreD;
  logic [1:0]     resultQ, resultD;
  logic           badQ, badD;
  logic           winQ, winD;
  logic           loseQ, loseD;
  logic [SW-1:0]  hInc, cInc;
  int             hi, ci;

  assign press = bus.enter & ~enterQ;
  assign hi    = moveIndex(bus.hMove);
  assign ci    = moveIndex(bus.cMove);
  assign hInc  = bcdInc(hScoreQ);
  assign cInc  = bcdInc(cScoreQ);

  // Register the FSM state, scores, flags and the enter edge detector; enterQ
  // resets high so a button held through reset never counts as a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      currState <= PLAY;
      enterQ    <= 1'b1;
      hScoreQ   <= '0;
      cScoreQ   <= '0;
      resultQ   <= 2'b00;
      badQ      <= 1'b0;
      winQ      <= 1'b0;
      loseQ     <= 1'b0;
    end else begin
      currState <= nextState;
      enterQ    <= bus.enter;
      hScoreQ   <= hScoreD;
      cScoreQ   <= cScoreD;
      resultQ   <= resultD;
      badQ      <= badD;
      winQ      <= winD;
      loseQ     <= loseD;
    end
  end

  // Next-state logic: newGame clears everything and wins over a press; a press
  // in PLAY evaluates the round, and in DONE everything holds.
  always_comb begin
    nextState = currState;
    hScoreD   = hScoreQ;
    cScoreD   = cScoreQ;
    resultD   = resultQ;
    badD      = badQ;
    winD      = winQ;
    loseD     = loseQ;
    if (bus.newGame) begin
      nextState = PLAY;
      hScoreD   = '0;
      cScoreD   = '0;
      resultD   = 2'b00;
      badD      = 1'b0;
      winD      = 1'b0;
      loseD     = 1'b0;
    end else if (press && currState == PLAY) begin
      if (!$onehot(bus.hMove) || !$onehot(bus.cMove)) begin
        badD    = 1'b1;
        resultD = 2'b00;
      end else begin
        badD = 1'b0;
        if (hi == ci) begin
          resultD = 2'b11;
        end else if (ci == (hi + NUM_MOVES - 1) % NUM_MOVES) begin
          resultD = 2'b01;
          hScoreD = hInc;
          if (hInc == WIN_BCD) begin
            winD      = 1'b1;
            nextState = DONE;
          end
        end else if (hi == (ci + NUM_MOVES - 1) % NUM_MOVES) begin
          resultD = 2'b10;
          cScoreD = cInc;
          if (cInc == WIN_BCD) begin
            loseD     = 1'b1;
            nextState = DONE;
          end
        end else begin
          resultD = 2'b00;
        end
      end
    end
  end

  assign bus.hScore      = hScoreQ;
  assign bus.cScore      = cScoreQ;
  assign bus.roundResult = resultQ;
  assign bus.badMove     = badQ;
  assign bus.win         = winQ;
  assign bus.lose        = loseQ;

endmodule
